// File: rtl/spi_slave_core.sv
// spi_slave_core: oversampled SPI slave with RX FIFO, TX holding register and error pulses
module spi_slave_core #(
    parameter int WIDTH       = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int LSB_FIRST   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                            sys_clk,
    input  logic                            sys_rst_n,
    input  logic                            spi_sclk,
    input  logic                            spi_mosi,
    input  logic                            spi_cs_n,
    output logic                            spi_miso,
    output logic [WIDTH-1:0]                rx_data,
    output logic                            rx_valid,
    input  logic                            rx_ready,
    input  logic [WIDTH-1:0]                tx_data,
    input  logic                            tx_valid,
    output logic                            tx_ready,
    output logic                            frame_err,
    output logic                            overflow,
    output logic                            busy,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);
    localparam int CW = $clog2(WIDTH);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic IDLE_SCLK = CPOL != 0;

    typedef enum logic {S_IDLE, S_ACTIVE} state_t;

    state_t                 r_state, w_state_nxt;
    logic [SYNC_STAGES-1:0] r_sclk_sync, r_mosi_sync, r_cs_sync, r_vld;
    logic                   r_sclk_h, r_cs_h, r_armed;
    logic                   w_sclk, w_mosi, w_cs, w_rise, w_fall, w_lead, w_trail;
    logic                   w_sample, w_shift, w_cs_fall, w_start, w_stop, w_abort, w_samp, w_last;
    logic [CW-1:0]          r_bit_cnt;
    logic [WIDTH-1:0]       r_rx_sh, r_tx_sh, r_hold;
    logic                   r_hold_full, r_done, r_frame_err, r_overflow;
    logic [WIDTH-1:0]       r_mem [FIFO_DEPTH];
    logic [AW-1:0]          r_wr, r_rd;
    logic [LW-1:0]          r_level;
    logic                   w_push, w_pop, w_full, w_acc;

    assign w_sclk    = r_sclk_sync[SYNC_STAGES-1];
    assign w_mosi    = r_mosi_sync[SYNC_STAGES-1];
    assign w_cs      = r_cs_sync[SYNC_STAGES-1];
    assign w_rise    = w_sclk & ~r_sclk_h;
    assign w_fall    = ~w_sclk & r_sclk_h;
    assign w_lead    = (CPOL != 0) ? w_fall : w_rise;
    assign w_trail   = (CPOL != 0) ? w_rise : w_fall;
    assign w_sample  = (CPHA != 0) ? w_trail : w_lead;
    assign w_shift   = (CPHA != 0) ? w_lead : w_trail;
    assign w_cs_fall = ~w_cs & r_cs_h;
    assign w_samp    = (r_state == S_ACTIVE) & ~w_cs & w_sample;
    assign w_last    = r_bit_cnt == CW'(WIDTH - 1);

    assign w_push = r_done;
    assign w_pop  = rx_valid & rx_ready;
    assign w_full = r_level == LW'(FIFO_DEPTH);
    assign w_acc  = w_push & (~w_full | w_pop);

    assign busy       = ~w_cs;
    assign spi_miso   = busy & ((LSB_FIRST != 0) ? r_tx_sh[0] : r_tx_sh[WIDTH-1]);
    assign rx_data    = r_mem[r_rd];
    assign rx_valid   = r_level != '0;
    assign tx_ready   = ~r_hold_full;
    assign frame_err  = r_frame_err;
    assign overflow   = r_overflow;
    assign fifo_level = r_level;

    // Pin synchronisers, edge history, and the arm flag that ignores CS low until a real CS high is seen
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_sclk_sync <= {SYNC_STAGES{IDLE_SCLK}};
            r_mosi_sync <= '0;
            r_cs_sync   <= '1;
            r_vld       <= '0;
            r_sclk_h    <= IDLE_SCLK;
            r_cs_h      <= 1'b1;
            r_armed     <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            r_vld       <= {r_vld[SYNC_STAGES-2:0], 1'b1};
            r_sclk_h    <= w_sclk;
            r_cs_h      <= w_cs;
            r_armed     <= r_armed | (r_vld[SYNC_STAGES-1] & w_cs);
        end
    end

    // Frame state register
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) r_state <= S_IDLE;
        else r_state <= w_state_nxt;
    end

    // Frame start on an armed CS fall; leaving ACTIVE mid-word flags a framing error
    always_comb begin
        w_start     = (r_state == S_IDLE) & w_cs_fall & r_armed;
        w_stop      = (r_state == S_ACTIVE) & w_cs;
        w_abort     = w_stop & (r_bit_cnt != '0);
        w_state_nxt = w_start ? S_ACTIVE : w_stop ? S_IDLE : r_state;
    end

    // Bit counter and shifters; the first shift edge of every word is skipped because its bit is already on MISO
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_bit_cnt   <= '0;
            r_rx_sh     <= '0;
            r_tx_sh     <= '0;
            r_done      <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_done      <= w_samp & w_last;
            r_frame_err <= w_abort;
            if (w_start) r_bit_cnt <= '0;
            else if (w_samp) r_bit_cnt <= w_last ? '0 : r_bit_cnt + 1'b1;
            if (w_samp) r_rx_sh <= (LSB_FIRST != 0) ? {w_mosi, r_rx_sh[WIDTH-1:1]} : {r_rx_sh[WIDTH-2:0], w_mosi};
            if (w_start || r_done) r_tx_sh <= r_hold;
            else if ((r_state == S_ACTIVE) && w_shift && (r_bit_cnt != '0)) r_tx_sh <= (LSB_FIRST != 0) ? r_tx_sh >> 1 : r_tx_sh << 1;
        end
    end

    // TX holding register; a load in the same cycle as a transfer lands after it
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_hold      <= '0;
            r_hold_full <= 1'b0;
        end else begin
            if (w_start || r_done) begin
                r_hold      <= '0;
                r_hold_full <= 1'b0;
            end
            if (tx_valid && !r_hold_full) begin
                r_hold      <= tx_data;
                r_hold_full <= 1'b1;
            end
        end
    end

    // RX FIFO storage
    always_ff @(posedge sys_clk) begin
        if (w_acc) r_mem[r_wr] <= r_rx_sh;
    end

    // RX FIFO pointers, occupancy and overflow pulse
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_wr       <= '0;
            r_rd       <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= w_push & w_full & ~w_pop;
            if (w_acc) r_wr <= r_wr + 1'b1;
            if (w_pop) r_rd <= r_rd + 1'b1;
            r_level <= r_level + LW'(w_acc) - LW'(w_pop);
        end
    end
endmodule

// File: tb/tb_spi_slave_core.sv
// tb_spi_slave_core: SPI master driving five slave configurations, checked against a queue model
`timescale 1ns/1ps
module tb_spi_slave_core;
    localparam int N = 5;
    localparam int H = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cs_n [N];
    logic       sclk [N];
    logic       mosi [N];
    logic       miso [N];
    logic [7:0] rx_data [N];
    logic       rx_valid [N];
    logic       rx_ready [N];
    logic [7:0] tx_data [N];
    logic       tx_valid [N];
    logic       tx_ready [N];
    logic       frame_err [N];
    logic       overflow [N];
    logic       busy [N];
    logic [2:0] fifo_level [N];

    int n_vec = 0, n_err = 0;
    int fe_cnt = 0, ov_cnt = 0, exp_fe = 0, exp_ov = 0;
    int lat_mode = 0;
    logic [7:0] q[$];
    logic [7:0] got, w, t;
    bit offer;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        spi_slave_core #(
            .WIDTH(8), .FIFO_DEPTH(4),
            .CPOL(g == 0 ? 0 : (g - 1) / 2), .CPHA(g == 0 ? 0 : (g - 1) % 2),
            .LSB_FIRST(g == 0 ? 1 : 0), .SYNC_STAGES(2)
        ) u_dut (
            .sys_clk(clk), .sys_rst_n(rst_n),
            .spi_sclk(sclk[g]), .spi_mosi(mosi[g]), .spi_cs_n(cs_n[g]), .spi_miso(miso[g]),
            .rx_data(rx_data[g]), .rx_valid(rx_valid[g]), .rx_ready(rx_ready[g]),
            .tx_data(tx_data[g]), .tx_valid(tx_valid[g]), .tx_ready(tx_ready[g]),
            .frame_err(frame_err[g]), .overflow(overflow[g]), .busy(busy[g]), .fifo_level(fifo_level[g])
        );
    end

    // Count pulse cycles of the default instance away from the active edge
    always @(negedge clk) begin
        if (frame_err[0] === 1'b1) fe_cnt++;
        if (overflow[0] === 1'b1) ov_cnt++;
    end

    function automatic int pol(input int k); return k == 0 ? 0 : (k - 1) / 2; endfunction
    function automatic int pha(input int k); return k == 0 ? 0 : (k - 1) % 2; endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic edge_wait(input int k, input bit last);
        if (last && k == 0 && lat_mode == 1) begin
            repeat (3) @(posedge clk);
            #1 chk("lat_early", rx_valid[0], 0);
            @(posedge clk);
            #1 chk("lat_valid", rx_valid[0], 1);
            chk("lat_level", fifo_level[0], 1);
            repeat (2) @(negedge clk);
        end else if (last && k == 0 && lat_mode == 2) begin
            repeat (3) @(posedge clk);
            #1 chk("pp_head", rx_data[0], q[0]);
            rx_ready[0] = 1'b1;
            @(posedge clk);
            #1 rx_ready[0] = 1'b0;
            void'(q.pop_front());
            repeat (2) @(negedge clk);
        end else repeat (H) @(negedge clk);
    endtask

    task automatic spi_bits(input int k, input logic [7:0] d, input int lo, input int hi, inout logic [7:0] rcv);
        for (int i = lo; i < hi; i++) begin
            int b;
            b = (k == 0) ? i : 7 - i;
            if (pha(k) == 0) begin
                mosi[k] = d[b];
                repeat (H) @(negedge clk);
                rcv[b] = miso[k];
                sclk[k] = ~sclk[k];
                edge_wait(k, i == 7);
                sclk[k] = ~sclk[k];
            end else begin
                sclk[k] = ~sclk[k];
                mosi[k] = d[b];
                repeat (H) @(negedge clk);
                rcv[b] = miso[k];
                sclk[k] = ~sclk[k];
                edge_wait(k, i == 7);
            end
        end
    endtask

    task automatic send(input int k, input logic [7:0] d, output logic [7:0] rcv);
        rcv = '0;
        cs_n[k] = 1'b0;
        repeat (10) @(negedge clk);
        spi_bits(k, d, 0, 8, rcv);
        cs_n[k] = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic model_push(input logic [7:0] d);
        if (q.size() < 4) q.push_back(d);
        else exp_ov++;
    endtask

    task automatic pop_chk();
        if (q.size() == 0) begin
            chk("empty_valid", rx_valid[0], 0);
            rx_ready[0] = 1'b1;
            @(negedge clk);
            rx_ready[0] = 1'b0;
            @(negedge clk);
            chk("empty_level", fifo_level[0], 0);
        end else begin
            chk("pop_valid", rx_valid[0], 1);
            chk("pop_data", rx_data[0], q.pop_front());
            rx_ready[0] = 1'b1;
            @(negedge clk);
            rx_ready[0] = 1'b0;
        end
    endtask

    task automatic tx_load(input int k, input logic [7:0] v);
        chk("tx_ready", tx_ready[k], 1);
        tx_data[k] = v;
        tx_valid[k] = 1'b1;
        @(negedge clk);
        tx_valid[k] = 1'b0;
        chk("tx_taken", tx_ready[k], 0);
    endtask

    // Watchdog so a stuck run still terminates
    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Directed scenarios followed by randomized traffic
    initial begin
        for (int k = 0; k < N; k++) begin
            cs_n[k] = 1'b1; sclk[k] = pol(k) != 0; mosi[k] = 1'b0;
            rx_ready[k] = 1'b0; tx_valid[k] = 1'b0; tx_data[k] = '0;
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_valid", rx_valid[0], 0);
        chk("rst_level", fifo_level[0], 0);
        chk("rst_tx_ready", tx_ready[0], 1);
        chk("rst_miso", miso[0], 0);
        chk("rst_busy", busy[0], 0);
        chk("rst_pulses", {frame_err[0], overflow[0]}, 0);

        lat_mode = 1;
        send(0, 8'hA5, got);
        lat_mode = 0;
        model_push(8'hA5);
        chk("t1_miso", got, 8'h00);
        pop_chk();

        for (int k = 1; k < N; k++) begin
            tx_load(k, 8'hC3);
            send(k, 8'h3C, got);
            chk($sformatf("mode%0d_valid", k - 1), rx_valid[k], 1);
            chk($sformatf("mode%0d_rx", k - 1), rx_data[k], 8'h3C);
            chk($sformatf("mode%0d_miso", k - 1), got, 8'hC3);
            chk($sformatf("mode%0d_idle_miso", k - 1), miso[k], 0);
        end

        for (int i = 1; i <= 5; i++) begin
            send(0, 8'(i), got);
            model_push(8'(i));
        end
        chk("ovf_level", fifo_level[0], 4);
        chk("ovf_count", ov_cnt, exp_ov);
        repeat (5) pop_chk();

        cs_n[0] = 1'b0;
        repeat (10) @(negedge clk);
        spi_bits(0, 8'hFF, 0, 5, got);
        cs_n[0] = 1'b1;
        repeat (10) @(negedge clk);
        exp_fe++;
        chk("fe_count", fe_cnt, exp_fe);
        chk("fe_no_push", fifo_level[0], 0);
        send(0, 8'h5A, got);
        model_push(8'h5A);
        pop_chk();
        chk("fe_count2", fe_cnt, exp_fe);

        for (int i = 0; i < 4; i++) begin
            send(0, 8'h10 + 8'(i), got);
            model_push(8'h10 + 8'(i));
        end
        lat_mode = 2;
        send(0, 8'h14, got);
        lat_mode = 0;
        model_push(8'h14);
        chk("pp_ovf", ov_cnt, exp_ov);
        chk("pp_level", fifo_level[0], 4);
        repeat (5) pop_chk();

        cs_n[0] = 1'b0;
        repeat (10) @(negedge clk);
        spi_bits(0, 8'h6B, 0, 3, got);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        spi_bits(0, 8'h6B, 3, 8, got);
        repeat (10) @(negedge clk);
        chk("rr_level", fifo_level[0], 0);
        chk("rr_valid", rx_valid[0], 0);
        cs_n[0] = 1'b1;
        repeat (10) @(negedge clk);
        chk("rr_fe", fe_cnt, exp_fe);
        send(0, 8'h96, got);
        model_push(8'h96);
        pop_chk();

        for (int n = 0; n < 30; n++) begin
            w = 8'($urandom);
            t = 8'($urandom);
            offer = 1'($urandom_range(0, 1));
            if (offer) tx_load(0, t);
            send(0, w, got);
            model_push(w);
            chk("rnd_miso", got, offer ? t : 8'h00);
            chk("rnd_level", fifo_level[0], q.size());
            chk("rnd_ovf", ov_cnt, exp_ov);
            repeat ($urandom_range(0, 2)) pop_chk();
        end
        while (q.size() != 0) pop_chk();
        pop_chk();
        chk("end_fe", fe_cnt, exp_fe);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/spi_slave_core.md
Name: spi_slave_core

Overview:
- Parametrised SPI slave for the TinyFPGA fabric.
- Oversamples SCLK, MOSI and CS_N in the sys_clk domain. Supports all four CPOL/CPHA modes and configurable word width and bit order.
- Received words are buffered in a small RX FIFO with valid/ready output. A TX holding register drives MISO.
- Framing errors and overflows are reported as single-cycle pulses for a status/LED block.

Parameters:
WIDTH, 8, bits per SPI word (2..32)
FIFO_DEPTH, 4, RX FIFO entries (power of 2, 2..16)
CPOL, 0, SCLK idle level
CPHA, 0, 0 = sample on leading edge, 1 = sample on trailing edge
LSB_FIRST, 1, 1 = first bit on wire is word bit 0; 0 = MSB first
SYNC_STAGES, 2, synchroniser flops on SCLK/MOSI/CS_N (2..3)

Ports:
sys_clk  in  1  system clock; all logic on rising edge
sys_rst_n  in  1  synchronous reset, active-low
spi_sclk  in  1  SPI clock (asynchronous)
spi_mosi  in  1  SPI data in (asynchronous)
spi_cs_n  in  1  chip select, active-low (asynchronous)
spi_miso  out  1  SPI data out; driven only while CS asserted, else 0
rx_data  out  WIDTH  FIFO head word
rx_valid  out  1  FIFO non-empty
rx_ready  in  1  consumer pop; pop occurs when rx_valid & rx_ready
tx_data  in  WIDTH  next word to shift out
tx_valid  in  1  tx_data offered
tx_ready  out  1  holding register empty; load occurs when tx_valid & tx_ready
frame_err  out  1  1-cycle pulse: CS deasserted mid-word
overflow  out  1  1-cycle pulse: completed word dropped, FIFO full
busy  out  1  CS asserted (synchronised)
fifo_level  out  $clog2(FIFO_DEPTH)+1  current RX occupancy

Behaviour:
- Reset (sys_rst_n=0 at a sys_clk edge):
  - FIFO empty, rx_valid=0, fifo_level=0.
  - tx_ready=1, holding register=0.
  - spi_miso=0, frame_err=0, overflow=0, busy=0.
  - bit counter=0, shift registers=0.
  - Synchroniser flops reset to idle: SCLK=CPOL, CS_N=1, MOSI=0.
  - Reset mid-frame discards the partial word. The slave rejoins only after CS rises and falls again; a synchronised CS low is not treated as a frame start until CS has first been seen high.
- Synchronisation: all three pins pass through SYNC_STAGES flops plus one history flop for edge detection. MOSI is delayed identically to SCLK.
- Sample edge = leading edge if CPHA=0, trailing edge if CPHA=1. Leading edge = rising if CPOL=0, falling if CPOL=1. Shift edge = the other edge.
- FSM:
  - IDLE:
    - CS falling edge: bit_cnt←0, load the TX shift register from the holding register, set tx_ready=1, go to ACTIVE.
    - If the holding register is empty, shift all-zero.
  - ACTIVE:
    - On sample edge: shift in MOSI per LSB_FIRST, bit_cnt++.
    - When bit_cnt reaches WIDTH-1 on a sample edge: the word is complete and bit_cnt wraps to 0.
    - On the next cycle: push to FIFO and reload the TX shift register from the holding register.
    - On shift edge: advance the TX shift register.
    - The CPHA=1 first-leading-edge shift is suppressed; the first bit is already presented.
    - CS rising with bit_cnt≠0: frame_err pulse, partial word discarded, go to IDLE.
    - CS rising with bit_cnt=0: go to IDLE silently.
- MISO timing:
  - spi_miso = current TX bit while busy, else 0.
  - With CPHA=0, bit 0 of the frame is valid within 1 cycle of synchronised CS low.
- Latency: word completes on the sampling SCLK edge. rx_valid is high from the (SYNC_STAGES+2)th sys_clk edge after that pin edge (4 edges for the default).
- Max SCLK: each SCLK high and low phase must be ≥ SYNC_STAGES+2 sys_clk periods. Behaviour at faster SCLK is undefined.
- FIFO:
  - Circular, pointers wrap modulo FIFO_DEPTH.
  - rx_data is registered head, valid whenever rx_valid=1.
  - Push while full without pop: word dropped, overflow pulse, contents unchanged.
  - Push while full with a pop in the same cycle: accepted; level unchanged.
  - Push and pop together when level is between 1 and FIFO_DEPTH-1: level unchanged.
  - Pop when empty is ignored.
- TX:
  - Holding register loads when tx_valid & tx_ready, then tx_ready=0.
  - It is transferred to the shifter at each word boundary, and tx_ready returns to 1 on the next cycle.
  - A load in the same cycle as a transfer takes effect after the transfer, so the new word is held for the following word.
- frame_err and overflow can pulse in the same cycle; they are independent.

Test Plan:
- Reset, mode 0, LSB_FIRST=1, WIDTH=8: send 0xA5 at SCLK = sys_clk/10 → rx_data=0xA5, rx_valid at 4th edge after the last rising SCLK, fifo_level=1.
- All four CPOL/CPHA modes, LSB_FIRST=0: master sends 0x3C while tx_data=0xC3 preloaded → rx_data=0x3C; master captures 0xC3 on MISO in each mode.
- rx_ready held 0, send 5 words (0x01..0x05), FIFO_DEPTH=4 → overflow pulses once on the 5th word; popping yields 0x01,0x02,0x03,0x04, then rx_valid=0.
- Raise CS after 5 bits, then send a full 0x5A → one frame_err pulse, no push for the partial word, next word 0x5A received correctly.
- Full FIFO, rx_ready=1 in the cycle a new word is pushed → no overflow, fifo_level stays 4, order preserved.
- Assert sys_rst_n=0 for 1 cycle after 3 bits with CS held low, then complete the frame → no word pushed. CS high then low, send 0x96 → rx_data=0x96.
